dmem_responder: RTL

Synchronous data-memory responder that sits on the core's data-memory port, opposite the load/store unit. It accepts one read or byte-masked write request at a time, adds a configurable number of wait states, and returns a one-cycle acknowledge with read data or an error flag. It replaces the behavioural data-memory model, giving the core a synthesizable memory with a defined handshake and fault reporting.

---
 rtl/dmem_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: DEPTH x 32 synchronous RAM behind a request/ack handshake.
// Latency: request accepted at edge n is acknowledged in the cycle after edge n+WAIT_STATES.
// Backpressure: one transaction in flight; requests seen in WAIT/RESP are ignored, and the core holds its request until dm_ack.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   dm_addr                  byte address (word index = dm_addr[AW+1:2])
//   dm_data_in, dm_wr_mask   write data and byte-lane enables
//   dm_wr_req, dm_rd_req     level-sensitive requests (write wins if both high)
//   dm_data_o, dm_ack, dm_err  read data, one-cycle completion pulse, fault flag
module dmem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_data_in,
  input  logic [3:0]  dm_wr_mask,
  input  logic        dm_wr_req,
  input  logic        dm_rd_req,
  output logic [31:0] dm_data_o,
  output logic        dm_ack,
  output logic        dm_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  logic [31:0] mem [DEPTH];

  state_t      state;
  logic [2:0]  cnt;

  // Request captured at acceptance; inputs are don't-care afterwards.
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_data;
  logic [3:0]    lat_mask;
  logic          lat_wr;
  logic          lat_fault;

  logic req;
  logic in_fault;

  assign req      = dm_wr_req | dm_rd_req;
  // Misaligned, or any address bit above the array set.
  assign in_fault = (dm_addr[1:0] != 2'b00) || (dm_addr[31:AW+2] != '0);

  // With zero wait states the access happens on the acceptance edge itself,
  // so the live inputs must be used instead of the (not yet loaded) latches.
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_data;
  logic [3:0]    acc_mask;
  logic          acc_wr;
  logic          acc_fault;
  logic          enter_resp;

  always_comb begin
    acc_idx    = lat_idx;
    acc_data   = lat_data;
    acc_mask   = lat_mask;
    acc_wr     = lat_wr;
    acc_fault  = lat_fault;
    enter_resp = 1'b0;
    if (state == S_IDLE) begin
      acc_idx   = dm_addr[AW+1:2];
      acc_data  = dm_data_in;
      acc_mask  = dm_wr_mask;
      acc_wr    = dm_wr_req;
      acc_fault = in_fault;
      enter_resp = req && (WAIT_STATES == 0);
    end else if (state == S_WAIT) begin
      enter_resp = (cnt == 3'd0);
    end
  end

  // Storage is not reset; a reset edge suppresses any commit on that edge.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_wr && !acc_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_mask[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= 3'd0;
      dm_ack    <= 1'b0;
      dm_err    <= 1'b0;
      dm_data_o <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_idx   <= dm_addr[AW+1:2];
            lat_data  <= dm_data_in;
            lat_mask  <= dm_wr_mask;
            lat_wr    <= dm_wr_req;
            lat_fault <= in_fault;
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= 3'(WAIT_STATES - 1);
            end
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) begin
            state <= S_RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Outputs are registered: the ack cycle is the cycle spent in RESP.
      if (enter_resp) begin
        dm_ack    <= 1'b1;
        dm_err    <= acc_fault;
        dm_data_o <= (acc_wr || acc_fault) ? 32'd0 : mem[acc_idx];
      end else begin
        dm_ack <= 1'b0;
        dm_err <= 1'b0;
      end
    end
  end

endmodule
